// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running VGA timing generator with sync, counters and active-video flags.
// Define VGA_SYNC_GEN_FRAME_COUNT_EN to add the 8-bit o_frame_count output.
module vga_sync_gen #(
    parameter int   TOTAL_COLS  = 800,
    parameter int   TOTAL_ROWS  = 525,
    parameter int   ACTIVE_COLS = 640,
    parameter int   ACTIVE_ROWS = 480,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter logic SYNC_POL    = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    output logic       o_hsync,
    output logic       o_vsync,
    output logic [9:0] o_col_count,
    output logic [9:0] o_row_count,
    output logic       o_active,
    output logic       o_frame_start
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
    ,
    output logic [7:0] o_frame_count
`endif
);
    localparam logic [9:0] COL_LAST = 10'(TOTAL_COLS - 1);
    localparam logic [9:0] ROW_LAST = 10'(TOTAL_ROWS - 1);
    localparam logic [9:0] ACT_COLS = 10'(ACTIVE_COLS);
    localparam logic [9:0] ACT_ROWS = 10'(ACTIVE_ROWS);
    localparam logic [9:0] HS_FIRST = 10'(ACTIVE_COLS + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(ACTIVE_COLS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(ACTIVE_ROWS + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(ACTIVE_ROWS + V_FP + V_SYNC - 1);

    logic [9:0] col_q, col_d, row_q, row_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic       active_q, active_d, frame_start_q, frame_start_d;

    // Flags are derived from the next counter value so they line up with the counters they accompany.
    always_comb begin
        col_d         = (col_q == COL_LAST) ? '0 : col_q + 10'd1;
        row_d         = (col_q != COL_LAST) ? row_q : (row_q == ROW_LAST) ? '0 : row_q + 10'd1;
        hsync_d       = (col_d >= HS_FIRST && col_d <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (row_d >= VS_FIRST && row_d <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        active_d      = (col_d < ACT_COLS) && (row_d < ACT_ROWS);
        frame_start_d = (col_d == '0) && (row_d == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q         <= COL_LAST;
            row_q         <= ROW_LAST;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            active_q      <= 1'b0;
            frame_start_q <= 1'b0;
        end else if (i_en) begin
            col_q         <= col_d;
            row_q         <= row_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            frame_start_q <= frame_start_d;
        end else begin
            frame_start_q <= 1'b0;
        end
    end

`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
    logic [7:0] frame_count_q;
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            frame_count_q <= '0;
        else if (i_en)
            frame_count_q <= frame_count_q + 8'(frame_start_d);
    end
    assign o_frame_count = frame_count_q;
`endif

    assign o_col_count   = col_q;
    assign o_row_count   = row_q;
    assign o_hsync       = hsync_q;
    assign o_vsync       = vsync_q;
    assign o_active      = active_q;
    assign o_frame_start = frame_start_q;

    initial begin
        if (ACTIVE_COLS + H_FP + H_SYNC > TOTAL_COLS)
            $error("vga_sync_gen: horizontal timing exceeds TOTAL_COLS");
        if (ACTIVE_ROWS + V_FP + V_SYNC > TOTAL_ROWS)
            $error("vga_sync_gen: vertical timing exceeds TOTAL_ROWS");
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: randomized scoreboard bench for vga_sync_gen on a reduced raster.
// Expected outputs come from a linear pixel-index model of the frame.
module tb_vga_sync_gen;
    localparam int   TC    = 20;
    localparam int   TR    = 12;
    localparam int   AC    = 12;
    localparam int   AR    = 8;
    localparam int   HFP   = 2;
    localparam int   HS    = 3;
    localparam int   VFP   = 1;
    localparam int   VS    = 2;
    localparam logic POL   = 1'b0;
    localparam int   FRAME = TC * TR;

    typedef struct packed {
        logic [9:0] col;
        logic [9:0] row;
        logic       hs;
        logic       vs;
        logic       act;
        logic       fs;
        logic [7:0] fc;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b0;
    logic       i_en  = 1'b0;
    logic       o_hsync, o_vsync, o_active, o_frame_start;
    logic [9:0] o_col_count, o_row_count;
    logic [7:0] fc_act;

    vga_sync_gen #(
        .TOTAL_COLS(TC), .TOTAL_ROWS(TR), .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
        .H_FP(HFP), .H_SYNC(HS), .V_FP(VFP), .V_SYNC(VS), .SYNC_POL(POL)
    ) dut (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_en(i_en),
        .o_hsync(o_hsync),
        .o_vsync(o_vsync),
        .o_col_count(o_col_count),
        .o_row_count(o_row_count),
        .o_active(o_active),
        .o_frame_start(o_frame_start)
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
        ,
        .o_frame_count(fc_act)
`endif
    );
`ifndef VGA_SYNC_GEN_FRAME_COUNT_EN
    assign fc_act = 8'd0;
`endif

    always #5 i_clk = ~i_clk;

    exp_t exp_q[$];
    exp_t cur;
    int   pix;
    int   compared   = 0;
    int   mismatched = 0;

    function automatic exp_t at_pix(int p, logic fs, logic [7:0] fc);
        exp_t e;
        int c, r;
        c = p % TC;
        r = p / TC;
        e.col = 10'(c);
        e.row = 10'(r);
        e.hs  = (c >= AC + HFP && c < AC + HFP + HS) ? POL : ~POL;
        e.vs  = (r >= AR + VFP && r < AR + VFP + VS) ? POL : ~POL;
        e.act = (c < AC) && (r < AR);
        e.fs  = fs;
        e.fc  = fc;
        return e;
    endfunction

    task automatic model_reset();
        pix     = FRAME - 1;
        cur.col = 10'(TC - 1);
        cur.row = 10'(TR - 1);
        cur.hs  = ~POL;
        cur.vs  = ~POL;
        cur.act = 1'b0;
        cur.fs  = 1'b0;
        cur.fc  = 8'd0;
    endtask

    task automatic model_step(input logic en);
        logic [7:0] fc;
        if (en) begin
            pix = (pix + 1) % FRAME;
            fc  = cur.fc;
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
            if (pix == 0) fc = fc + 8'd1;
`endif
            cur = at_pix(pix, pix == 0, fc);
        end else begin
            cur.fs = 1'b0;
        end
    endtask

    task automatic cyc(input logic en);
        @(negedge i_clk);
        i_en = en;
        model_step(en);
        exp_q.push_back(cur);
    endtask

    // One entry for the asynchronous assertion, one for the clock edge seen while held, one after release.
    task automatic rst_pulse(input logic en_after);
        @(negedge i_clk);
        model_reset();
        exp_q.push_back(cur);
        exp_q.push_back(cur);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        i_en  = en_after;
        model_step(en_after);
        exp_q.push_back(cur);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge i_clk or posedge i_rst);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                compared++;
                if (o_col_count !== e.col || o_row_count !== e.row || o_hsync !== e.hs ||
                    o_vsync !== e.vs || o_active !== e.act || o_frame_start !== e.fs
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
                    || fc_act !== e.fc
`endif
                   ) begin
                    mismatched++;
                    $display("FAIL outputs t=%0t got col=%0d row=%0d hs=%b vs=%b act=%b fs=%b fc=%0d expected col=%0d row=%0d hs=%b vs=%b act=%b fs=%b fc=%0d",
                             $time, o_col_count, o_row_count, o_hsync, o_vsync, o_active, o_frame_start, fc_act,
                             e.col, e.row, e.hs, e.vs, e.act, e.fs, e.fc);
                end
            end
        end
    end

    initial begin : watchdog
        #950_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        model_reset();
        rst_pulse(1'b1);
        for (int i = 0; i < 2 * FRAME; i++) cyc(1'b1);
        while (cur.col != 10'(AC + HFP - 1)) cyc(1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1);
        while (cur.row != 10'(AR / 2) || cur.col != 10'(AC / 2)) cyc(1'b1);
        rst_pulse(1'b1);
        for (int i = 0; i < 8 * FRAME; i++) begin
            if ($urandom_range(0, 299) == 0)
                rst_pulse(1'($urandom_range(0, 1)));
            else
                cyc($urandom_range(0, 4) != 0);
        end
`ifdef VGA_SYNC_GEN_FRAME_COUNT_EN
        rst_pulse(1'b1);
        for (int i = 0; i < 257 * FRAME + 5; i++) cyc(1'b1);
`endif
        @(posedge i_clk);
        #2;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
